// File: rtl/instr_packer.sv
// instr_packer: packs opcode/register/constant fields into 32-bit instruction
// words and streams them into instruction memory, one word per two cycles.
// Ports: clk, clr (sync active-high); start/base_addr open a session;
// in_valid/in_ready/in_last with fmt/opcode/ra/rb/rc/imm form the input;
// mem_we/mem_addr/mem_wdata write memory; busy/done/full/err_range/words
// report session status.
module instr_packer #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [4:0]        opcode,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic [3:0]        rc,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_range,
    output logic [ADDR_W:0]   words
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic              ok_q, ok_d;
    logic              last_q, last_d;

    logic              imm_fits;
    logic              has_imm;
    logic [31:0]       packed_w;

    // imm fits in 19 bits when bits 31..18 are a pure sign extension
    assign imm_fits = (imm[31:18] == 14'h0000) || (imm[31:18] == 14'h3fff);
    assign has_imm  = (fmt == 2'd1) || (fmt == 2'd2);

    always_comb begin
        packed_w = {opcode, ra, 23'b0};
        unique case (fmt)
            2'd0:    packed_w[22:15] = {rb, rc};
            2'd1,
            2'd2:    packed_w[22:0]  = {rb, imm[18:0]};
            default: packed_w[22:0]  = 23'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        err_d   = err_q;
        ok_d    = ok_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_FULL: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    addr_d  = base_addr;
                    words_d = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    ok_d    = !has_imm || imm_fits;
                    last_d  = in_last;
                    state_d = S_WRITE;
                    if (!has_imm || imm_fits) begin
                        wdata_d = packed_w;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (ok_q) begin
                    words_d = words_q + 1'b1;
                    if (addr_q != ADDR_MAX) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == ADDR_MAX) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == S_ACCEPT);
    assign mem_we    = (state_q == S_WRITE) && ok_q;
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign full      = (state_q == S_FULL);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign words     = words_q;
    assign err_range = err_q;

endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: scoreboard bench for instr_packer; expected writes are
// queued when a word is offered and checked when mem_we fires.
module tb_instr_packer;

    localparam int ADDR_W = 9;
    localparam int AMAX   = (1 << ADDR_W) - 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        fmt;
    logic [4:0]        opcode;
    logic [3:0]        ra, rb, rc;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, full, err_range;
    logic [ADDR_W:0]   words;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_addr = 0;
    int   m_words = 0;

    always #5 clk = ~clk;

    instr_packer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .clr(clr), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .full(full), .err_range(err_range),
        .words(words)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pack(input int f, input int op,
        input int a, input int b, input int c, input logic [31:0] im);
        logic [31:0] w;
        w = (op << 27) | (a << 23);
        if (f == 0) w = w | (b << 19) | (c << 15);
        else if (f == 1 || f == 2) w = w | (b << 19) | (im & 32'h0007_ffff);
        return w;
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int b);
        base_addr = ADDR_W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        m_addr = b;
        m_words = 0;
    endtask

    task automatic send(input int f, input int op, input int a, input int b,
                        input int c, input logic [31:0] im, input bit last,
                        input bit exp_wr);
        int n;
        fmt = 2'(f);
        opcode = 5'(op);
        ra = 4'(a);
        rb = 4'(b);
        rc = 4'(c);
        imm = im;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (exp_wr) begin
                exp_t e;
                e.addr = 32'(m_addr);
                e.data = model_pack(f, op, a, b, c, im);
                sb_q.push_back(e);
            end
            step();
            in_valid = 1'b0;
            chk("rdy_in_write", 32'(in_ready), 32'd0);
            if (exp_wr) begin
                m_words++;
                if (m_addr != AMAX) m_addr++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        fmt = '0;
        opcode = '0;
        ra = '0;
        rb = '0;
        rc = '0;
        imm = '0;
        repeat (2) step();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err_range), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_words", 32'(words), 0);
        clr = 1'b0;
        step();

        // single R word, last
        pulse_start(0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(in_ready), 1);
        send(0, 5'h03, 1, 2, 3, 32'd0, 1'b1, 1'b1);
        chk("t1_we", 32'(mem_we), 1);
        step();
        chk("t1_done", 32'(done), 1);
        chk("t1_words", 32'(words), 1);
        chk("t1_busy_off", 32'(busy), 0);
        step();
        chk("t1_done_off", 32'(done), 0);

        // I format, legal negative then out-of-range
        pulse_start(20);
        send(1, 5'h04, 4, 0, 0, -32'sd5, 1'b0, 1'b1);
        send(1, 5'h04, 4, 0, 0, 32'h0004_0000, 1'b0, 1'b0);
        chk("t2_err", 32'(err_range), 1);
        chk("t2_no_we", 32'(mem_we), 0);
        step();
        chk("t2_addr_hold", 32'(mem_addr), 21);
        chk("t2_words_hold", 32'(words), 1);
        send(3, 5'h1f, 7, 9, 9, 32'd123, 1'b1, 1'b1);
        step();
        chk("t2_done", 32'(done), 1);
        chk("t2_words", 32'(words), 2);
        chk("t2_addr", 32'(mem_addr), 22);
        chk("t2_err_sticky", 32'(err_range), 1);
        step();

        // back-to-back stream with range boundaries
        pulse_start(10);
        chk("t3_err_clr", 32'(err_range), 0);
        chk("t3_words0", 32'(words), 0);
        send(0, 5'h11, 15, 14, 13, 32'd0, 1'b0, 1'b1);
        send(2, 5'h0a, 3, 5, 0, 32'h0003_ffff, 1'b0, 1'b1);
        send(2, 5'h0b, 6, 8, 0, 32'hfffc_0000, 1'b0, 1'b1);
        send(1, 5'h0c, 2, 1, 0, 32'd1, 1'b1, 1'b1);
        step();
        chk("t3_done", 32'(done), 1);
        chk("t3_words", 32'(words), 4);
        chk("t3_addr", 32'(mem_addr), 14);
        chk("t3_err", 32'(err_range), 0);
        step();

        // top-of-memory halt
        pulse_start(AMAX - 1);
        send(0, 5'h01, 1, 1, 1, 32'd0, 1'b0, 1'b1);
        send(0, 5'h02, 2, 2, 2, 32'd0, 1'b0, 1'b1);
        step();
        chk("t4_full", 32'(full), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_addr", 32'(mem_addr), AMAX);
        chk("t4_words", 32'(words), 2);
        in_valid = 1'b1;
        repeat (3) begin
            chk("t4_no_ready", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        chk("t4_full_hold", 32'(full), 1);
        pulse_start(0);
        chk("t4_full_clr", 32'(full), 0);
        chk("t4_resume", 32'(in_ready), 1);
        chk("t4_addr0", 32'(mem_addr), 0);
        chk("t4_words0", 32'(words), 0);
        send(0, 5'h03, 3, 3, 3, 32'd0, 1'b1, 1'b1);
        repeat (2) step();

        // clr during WRITE
        pulse_start(100);
        send(0, 5'h05, 5, 5, 5, 32'd0, 1'b0, 1'b1);
        clr = 1'b1;
        step();
        chk("t5_we", 32'(mem_we), 0);
        chk("t5_ready", 32'(in_ready), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_addr", 32'(mem_addr), 0);
        chk("t5_words", 32'(words), 0);
        chk("t5_wdata", mem_wdata, 0);
        clr = 1'b0;
        step();
        chk("t5_idle", 32'(busy), 0);

        // start ignored while accepting
        pulse_start(40);
        base_addr = ADDR_W'(99);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_addr", 32'(mem_addr), 40);
        chk("t6_ready", 32'(in_ready), 1);
        send(1, 5'h06, 1, 2, 0, 32'd77, 1'b1, 1'b1);
        step();
        chk("t6_done", 32'(done), 1);
        chk("t6_words", 32'(words), 1);
        step();

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
